// File: rtl/bcd_updown_counter_7seg_mux.sv
// Multi-digit BCD up/down counter with prescaled stepping, clamped parallel load,
// wrap/saturate bounds, and a time-multiplexed active-low 7-segment display driver.
module bcd_updown_counter_7seg_mux #(
  parameter int DIGITS   = 4,
  parameter int DIV      = 10,
  parameter int SCAN_DIV = 4,
  parameter int SATURATE = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  upDown,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_value,
  output logic [4*DIGITS-1:0]   count,
  output logic [6:0]            seg7,
  output logic [DIGITS-1:0]     an,
  output logic                  wrap
);

  localparam int PW = (DIV > 1)      ? $clog2(DIV)      : 1;
  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = (DIGITS > 1)   ? $clog2(DIGITS)   : 1;

  localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);
  localparam logic [SW-1:0] SCAN_LAST  = SW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(DIGITS - 1);

  logic [4*DIGITS-1:0] count_q, count_d;
  logic [4*DIGITS-1:0] inc_val, dec_val, clamp_val;
  logic                all_nines, all_zero;
  logic [PW-1:0]       presc_q, presc_d;
  logic [SW-1:0]       scan_tmr_q, scan_tmr_d;
  logic [IW-1:0]       scan_idx_q, scan_idx_d;
  logic                wrap_q, wrap_d;
  logic [3:0]          sel_digit;

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    case (d)
      4'd0:    seg_decode = 7'b0000001;
      4'd1:    seg_decode = 7'b1001111;
      4'd2:    seg_decode = 7'b0010010;
      4'd3:    seg_decode = 7'b0000110;
      4'd4:    seg_decode = 7'b1001100;
      4'd5:    seg_decode = 7'b0100100;
      4'd6:    seg_decode = 7'b0100000;
      4'd7:    seg_decode = 7'b0001111;
      4'd8:    seg_decode = 7'b0000000;
      4'd9:    seg_decode = 7'b0000100;
      default: seg_decode = 7'b1111111;
    endcase
  endfunction

  // Ripple carry/borrow: a surviving carry-out means every digit was 9 (or 0).
  always_comb begin : bcd_arith
    logic carry, borrow;
    // NOTE: every combinational output gets a default first so no path infers a latch.
    carry     = 1'b1;
    borrow    = 1'b1;
    inc_val   = count_q;
    dec_val   = count_q;
    clamp_val = load_value;
    for (int i = 0; i < DIGITS; i++) begin
      if (carry) begin
        if (count_q[4*i +: 4] == 4'd9) begin
          inc_val[4*i +: 4] = 4'd0;
        end else begin
          inc_val[4*i +: 4] = count_q[4*i +: 4] + 4'd1;
          carry = 1'b0;
        end
      end
      if (borrow) begin
        if (count_q[4*i +: 4] == 4'd0) begin
          dec_val[4*i +: 4] = 4'd9;
        end else begin
          dec_val[4*i +: 4] = count_q[4*i +: 4] - 4'd1;
          borrow = 1'b0;
        end
      end
      if (load_value[4*i +: 4] > 4'd9) clamp_val[4*i +: 4] = 4'd9;
    end
    all_nines = carry;
    all_zero  = borrow;
  end

  always_comb begin : count_next
    count_d = count_q;
    presc_d = presc_q;
    wrap_d  = 1'b0;
    if (load) begin
      count_d = clamp_val;
      presc_d = '0;
    end else if (enable) begin
      if (presc_q == PRESC_LAST) begin
        presc_d = '0;
        if (upDown) begin
          if (!all_nines) begin
            count_d = inc_val;
          end else if (SATURATE == 0) begin
            count_d = inc_val;
            wrap_d  = 1'b1;
          end
        end else begin
          if (!all_zero) begin
            count_d = dec_val;
          end else if (SATURATE == 0) begin
            count_d = dec_val;
            wrap_d  = 1'b1;
          end
        end
      end else begin
        presc_d = presc_q + PW'(1);
      end
    end
  end

  always_comb begin : scan_next
    scan_tmr_d = scan_tmr_q + SW'(1);
    scan_idx_d = scan_idx_q;
    if (scan_tmr_q == SCAN_LAST) begin
      scan_tmr_d = '0;
      scan_idx_d = (scan_idx_q == IDX_LAST) ? '0 : scan_idx_q + IW'(1);
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      count_q    <= '0;
      presc_q    <= '0;
      scan_tmr_q <= '0;
      scan_idx_q <= '0;
      wrap_q     <= 1'b0;
    end else begin
      count_q    <= count_d;
      presc_q    <= presc_d;
      scan_tmr_q <= scan_tmr_d;
      scan_idx_q <= scan_idx_d;
      wrap_q     <= wrap_d;
    end
  end

  // Digit select mux and anode drive share one compare against the scan index.
  always_comb begin : display
    sel_digit = 4'd0;
    an        = '1;
    for (int i = 0; i < DIGITS; i++) begin
      if (scan_idx_q == IW'(i)) begin
        sel_digit = count_q[4*i +: 4];
        an[i]     = 1'b0;
      end
    end
    seg7 = seg_decode(sel_digit);
  end

  assign count = count_q;
  assign wrap  = wrap_q;

endmodule

// File: tb/tb_bcd_updown_counter_7seg_mux.sv
// Directed bench: one single-digit instance (DIV=10) and two four-digit instances
// (DIV=1, wrap and saturate) checked against hand-computed values.
module tb_bcd_updown_counter_7seg_mux;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  logic [6:0] seg_tab [0:9] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
                                7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100};

  // single digit, DIV=10, SCAN_DIV=1
  logic       rst1, en1, ud1, ld1, wrap1;
  logic [3:0] lv1, cnt1;
  logic [6:0] seg1;
  logic [0:0] an1;
  // four digits, DIV=1, SCAN_DIV=4, wrap
  logic        rst4, en4, ud4, ld4, wrap4;
  logic [15:0] lv4, cnt4;
  logic [6:0]  seg4;
  logic [3:0]  an4;
  // four digits, DIV=1, saturate
  logic        rsts, ens, uds, lds, wraps;
  logic [15:0] lvs, cnts;
  logic [6:0]  segs;
  logic [3:0]  ans;

  bcd_updown_counter_7seg_mux #(.DIGITS(1), .DIV(10), .SCAN_DIV(1), .SATURATE(0)) dut1 (
    .clk(clk), .rst(rst1), .enable(en1), .upDown(ud1), .load(ld1), .load_value(lv1),
    .count(cnt1), .seg7(seg1), .an(an1), .wrap(wrap1));

  bcd_updown_counter_7seg_mux #(.DIGITS(4), .DIV(1), .SCAN_DIV(4), .SATURATE(0)) dut4 (
    .clk(clk), .rst(rst4), .enable(en4), .upDown(ud4), .load(ld4), .load_value(lv4),
    .count(cnt4), .seg7(seg4), .an(an4), .wrap(wrap4));

  bcd_updown_counter_7seg_mux #(.DIGITS(4), .DIV(1), .SCAN_DIV(4), .SATURATE(1)) duts (
    .clk(clk), .rst(rsts), .enable(ens), .upDown(uds), .load(lds), .load_value(lvs),
    .count(cnts), .seg7(segs), .an(ans), .wrap(wraps));

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset;
    tick(5);
    vectors++; if ({cnt1, wrap1, an1, seg1} !== {4'd0, 1'b0, 1'b0, 7'b0000001}) begin
      miscompares++; $display("FAIL reset_d1: got %h/%b/%b/%b expected 0/0/0/0000001", cnt1, wrap1, an1, seg1); end
    vectors++; if ({cnt4, wrap4, an4, seg4} !== {16'h0000, 1'b0, 4'b1110, 7'b0000001}) begin
      miscompares++; $display("FAIL reset_d4: got %h/%b/%b/%b expected 0000/0/1110/0000001", cnt4, wrap4, an4, seg4); end
    vectors++; if ({cnts, wraps, ans} !== {16'h0000, 1'b0, 4'b1110}) begin
      miscompares++; $display("FAIL reset_ds: got %h/%b/%b expected 0000/0/1110", cnts, wraps, ans); end
  endtask

  task automatic test_count_up;
    rst1 = 1'b0; en1 = 1'b1; ud1 = 1'b1;
    for (int v = 1; v <= 9; v++) begin
      tick(9);
      vectors++; if (cnt1 !== 4'(v - 1)) begin
        miscompares++; $display("FAIL up_hold v=%0d: got %h expected %h", v, cnt1, 4'(v - 1)); end
      tick(1);
      vectors++; if ({cnt1, seg1, wrap1} !== {4'(v), seg_tab[v], 1'b0}) begin
        miscompares++; $display("FAIL up_step v=%0d: got %h/%b/%b expected %h/%b/0", v, cnt1, seg1, wrap1, 4'(v), seg_tab[v]); end
    end
    tick(9);
    vectors++; if ({cnt1, wrap1} !== {4'd9, 1'b0}) begin
      miscompares++; $display("FAIL up_pre_wrap: got %h/%b expected 9/0", cnt1, wrap1); end
    tick(1);
    vectors++; if ({cnt1, wrap1, seg1} !== {4'd0, 1'b1, 7'b0000001}) begin
      miscompares++; $display("FAIL up_wrap: got %h/%b/%b expected 0/1/0000001", cnt1, wrap1, seg1); end
    tick(1);
    vectors++; if ({cnt1, wrap1} !== {4'd0, 1'b0}) begin
      miscompares++; $display("FAIL up_wrap_pulse: got %h/%b expected 0/0", cnt1, wrap1); end
  endtask

  task automatic test_freeze;
    en1 = 1'b0; ld1 = 1'b1; lv1 = 4'd5;
    tick(1);
    ld1 = 1'b0;
    vectors++; if (cnt1 !== 4'd5) begin
      miscompares++; $display("FAIL freeze_load: got %h expected 5", cnt1); end
    en1 = 1'b1;
    tick(4);
    en1 = 1'b0;
    for (int c = 0; c < 40; c++) begin
      tick(1);
      vectors++; if ({cnt1, seg1} !== {4'd5, 7'b0100100}) begin
        miscompares++; $display("FAIL freeze_hold c=%0d: got %h/%b expected 5/0100100", c, cnt1, seg1); end
    end
    en1 = 1'b1;
    tick(5);
    vectors++; if (cnt1 !== 4'd5) begin
      miscompares++; $display("FAIL freeze_resume_hold: got %h expected 5", cnt1); end
    tick(1);
    vectors++; if ({cnt1, seg1} !== {4'd6, 7'b0100000}) begin
      miscompares++; $display("FAIL freeze_resume_6: got %h/%b expected 6/0100000", cnt1, seg1); end
    tick(9);
    vectors++; if (cnt1 !== 4'd6) begin
      miscompares++; $display("FAIL freeze_hold_6: got %h expected 6", cnt1); end
    tick(1);
    vectors++; if ({cnt1, seg1} !== {4'd7, 7'b0001111}) begin
      miscompares++; $display("FAIL freeze_resume_7: got %h/%b expected 7/0001111", cnt1, seg1); end
    // direction flip mid-phase keeps the prescaler phase
    tick(4);
    ud1 = 1'b0;
    tick(5);
    vectors++; if (cnt1 !== 4'd7) begin
      miscompares++; $display("FAIL dir_flip_hold: got %h expected 7", cnt1); end
    tick(1);
    vectors++; if (cnt1 !== 4'd6) begin
      miscompares++; $display("FAIL dir_flip_step: got %h expected 6", cnt1); end
  endtask

  task automatic test_load_priority;
    // single digit: load clears a partial prescaler phase and clamps >9
    ud1 = 1'b1; en1 = 1'b1;
    tick(3);
    ld1 = 1'b1; lv1 = 4'hC;
    tick(1);
    ld1 = 1'b0;
    vectors++; if (cnt1 !== 4'd9) begin
      miscompares++; $display("FAIL load_clamp_d1: got %h expected 9", cnt1); end
    tick(9);
    vectors++; if ({cnt1, wrap1} !== {4'd9, 1'b0}) begin
      miscompares++; $display("FAIL load_presc_clear_hold: got %h/%b expected 9/0", cnt1, wrap1); end
    tick(1);
    vectors++; if ({cnt1, wrap1} !== {4'd0, 1'b1}) begin
      miscompares++; $display("FAIL load_presc_clear_step: got %h/%b expected 0/1", cnt1, wrap1); end
    // four digits: load beats a step on the same edge
    en4 = 1'b1; ud4 = 1'b1; ld4 = 1'b1; lv4 = 16'h12F4;
    tick(1);
    ld4 = 1'b0;
    vectors++; if ({cnt4, wrap4} !== {16'h1294, 1'b0}) begin
      miscompares++; $display("FAIL load_over_step: got %h/%b expected 1294/0", cnt4, wrap4); end
    tick(1);
    vectors++; if (cnt4 !== 16'h1295) begin
      miscompares++; $display("FAIL load_then_step: got %h expected 1295", cnt4); end
    ld4 = 1'b1; lv4 = 16'hFAB9;
    tick(1);
    vectors++; if (cnt4 !== 16'h9999) begin
      miscompares++; $display("FAIL load_clamp_all: got %h expected 9999", cnt4); end
    rst4 = 1'b1; lv4 = 16'h5678;
    tick(1);
    rst4 = 1'b0; ld4 = 1'b0; en4 = 1'b0;
    vectors++; if ({cnt4, wrap4} !== {16'h0000, 1'b0}) begin
      miscompares++; $display("FAIL rst_over_load: got %h/%b expected 0000/0", cnt4, wrap4); end
  endtask

  task automatic test_ripple;
    rst4 = 1'b0; en4 = 1'b0; ld4 = 1'b1; lv4 = 16'h0999;
    tick(1);
    ld4 = 1'b0; en4 = 1'b1; ud4 = 1'b1;
    tick(1);
    vectors++; if ({cnt4, wrap4} !== {16'h1000, 1'b0}) begin
      miscompares++; $display("FAIL ripple_up: got %h/%b expected 1000/0", cnt4, wrap4); end
    ud4 = 1'b0;
    tick(1);
    vectors++; if (cnt4 !== 16'h0999) begin
      miscompares++; $display("FAIL ripple_down: got %h expected 0999", cnt4); end
    tick(1);
    vectors++; if (cnt4 !== 16'h0998) begin
      miscompares++; $display("FAIL down_0998: got %h expected 0998", cnt4); end
    tick(997);
    vectors++; if (cnt4 !== 16'h0001) begin
      miscompares++; $display("FAIL down_0001: got %h expected 0001", cnt4); end
    tick(1);
    vectors++; if ({cnt4, wrap4} !== {16'h0000, 1'b0}) begin
      miscompares++; $display("FAIL down_0000: got %h/%b expected 0000/0", cnt4, wrap4); end
    tick(1);
    vectors++; if ({cnt4, wrap4} !== {16'h9999, 1'b1}) begin
      miscompares++; $display("FAIL down_wrap: got %h/%b expected 9999/1", cnt4, wrap4); end
    en4 = 1'b0;
    tick(1);
    vectors++; if ({cnt4, wrap4} !== {16'h9999, 1'b0}) begin
      miscompares++; $display("FAIL down_wrap_pulse: got %h/%b expected 9999/0", cnt4, wrap4); end
    en4 = 1'b1; ud4 = 1'b1;
    tick(1);
    en4 = 1'b0;
    vectors++; if ({cnt4, wrap4} !== {16'h0000, 1'b1}) begin
      miscompares++; $display("FAIL up_wrap4: got %h/%b expected 0000/1", cnt4, wrap4); end
  endtask

  task automatic test_saturate;
    rsts = 1'b0; ens = 1'b0; lds = 1'b1; lvs = 16'h9998;
    tick(1);
    lds = 1'b0; ens = 1'b1; uds = 1'b1;
    for (int s = 0; s < 3; s++) begin
      tick(1);
      vectors++; if ({cnts, wraps} !== {16'h9999, 1'b0}) begin
        miscompares++; $display("FAIL sat_up s=%0d: got %h/%b expected 9999/0", s, cnts, wraps); end
    end
    ens = 1'b0; lds = 1'b1; lvs = 16'h0001;
    tick(1);
    lds = 1'b0; ens = 1'b1; uds = 1'b0;
    for (int s = 0; s < 3; s++) begin
      tick(1);
      vectors++; if ({cnts, wraps} !== {16'h0000, 1'b0}) begin
        miscompares++; $display("FAIL sat_down s=%0d: got %h/%b expected 0000/0", s, cnts, wraps); end
    end
    ens = 1'b0;
  endtask

  task automatic test_scan;
    logic [15:0] val;
    int          idx;
    logic [3:0]  exp_an, dig;
    val = 16'h1234;
    en4 = 1'b0; ld4 = 1'b0; rst4 = 1'b1;
    tick(1);
    rst4 = 1'b0; ld4 = 1'b1; lv4 = val;
    for (int k = 1; k <= 24; k++) begin
      tick(1);
      ld4    = 1'b0;
      idx    = (k / 4) % 4;
      exp_an = ~(4'b0001 << idx);
      dig    = 4'((val >> (4 * idx)) & 16'h000F);
      vectors++; if ({an4, seg4} !== {exp_an, seg_tab[dig]}) begin
        miscompares++; $display("FAIL scan k=%0d: got %b/%b expected %b/%b", k, an4, seg4, exp_an, seg_tab[dig]); end
    end
    // index is 2 here; reset mid-scan returns to digit 0
    rst4 = 1'b1;
    tick(1);
    rst4 = 1'b0;
    vectors++; if ({an4, seg4, cnt4} !== {4'b1110, 7'b0000001, 16'h0000}) begin
      miscompares++; $display("FAIL scan_rst: got %b/%b/%h expected 1110/0000001/0000", an4, seg4, cnt4); end
  endtask

  initial begin
    rst1 = 1'b1; en1 = 1'b0; ud1 = 1'b1; ld1 = 1'b0; lv1 = '0;
    rst4 = 1'b1; en4 = 1'b0; ud4 = 1'b1; ld4 = 1'b0; lv4 = '0;
    rsts = 1'b1; ens = 1'b0; uds = 1'b1; lds = 1'b0; lvs = '0;
    test_reset();
    test_count_up();
    test_freeze();
    test_ripple();
    test_load_priority();
    test_saturate();
    test_scan();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
